// File: rtl/br_pred.sv
// Bimodal branch predictor with a direct-mapped BTB. Lookups register one cycle
// after the fetch PC; resolved branches from EX train the counters and BTB.
module br_pred #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_valid,
    input  logic [63:0] f_pc,
    input  logic        f_stall,
    input  logic        flush,
    output logic        p_valid,
    output logic [63:0] p_pc,
    output logic        p_taken,
    output logic [63:0] p_target,
    input  logic        u_valid,
    input  logic [63:0] u_pc,
    input  logic        u_taken,
    input  logic [63:0] u_target,
    input  logic        u_miss,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       cnt_q     [DEPTH];
    logic             btb_v_q   [DEPTH];
    logic [TAG_W-1:0] btb_tag_q [DEPTH];
    logic [63:0]      btb_tgt_q [DEPTH];

    logic             p_valid_q, p_taken_q;
    logic [63:0]      p_pc_q, p_target_q;
    logic [31:0]      br_cnt_q, miss_cnt_q;

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, p_taken_d;
    logic [63:0]      p_target_d;
    logic [1:0]       cnt_d;
    logic             u_pc_unused;

    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = u_pc[IDX_W+1:2];
    assign u_tag = u_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign u_pc_unused = ^{u_pc[63:IDX_W+TAG_W+2], u_pc[1:0]};

    // Lookup reads the current table contents, so a same-cycle update is not bypassed.
    always_comb begin
        f_hit      = btb_v_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
        p_taken_d  = cnt_q[f_idx][1] && f_hit;
        p_target_d = p_taken_d ? btb_tgt_q[f_idx] : f_pc + 64'd4;
    end

    always_comb begin
        cnt_d = cnt_q[u_idx];
        if (u_taken) begin
            if (cnt_q[u_idx] != 2'b11) cnt_d = cnt_q[u_idx] + 2'b01;
        end else begin
            if (cnt_q[u_idx] != 2'b00) cnt_d = cnt_q[u_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid_q  <= 1'b0;
            p_pc_q     <= 64'd0;
            p_taken_q  <= 1'b0;
            p_target_q <= 64'd0;
        end else if (flush) begin
            p_valid_q  <= 1'b0;
        end else if (!f_stall) begin
            p_valid_q  <= f_valid;
            p_pc_q     <= f_pc;
            p_taken_q  <= p_taken_d;
            p_target_q <= p_target_d;
        end
    end

    // Only counters and valid bits need reset; stale tags/targets are masked by valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i]   <= 2'b01;
                btb_v_q[i] <= 1'b0;
            end
        end else if (u_valid) begin
            cnt_q[u_idx] <= cnt_d;
            if (u_taken) btb_v_q[u_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (u_valid && u_taken) begin
            btb_tag_q[u_idx] <= u_tag;
            btb_tgt_q[u_idx] <= u_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q   <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (u_valid) begin
            br_cnt_q <= br_cnt_q + 32'd1;
            if (u_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign p_valid  = p_valid_q;
    assign p_pc     = p_pc_q;
    assign p_taken  = p_taken_q;
    assign p_target = p_target_q;
    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_br_pred.sv
// Directed testbench for br_pred: lookup latency, training, hysteresis, aliasing,
// same-cycle update/lookup, stall/flush, statistics and asynchronous reset.
module tb_br_pred;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid, f_stall, flush;
    logic [63:0] f_pc;
    logic        p_valid, p_taken;
    logic [63:0] p_pc, p_target;
    logic        u_valid, u_taken, u_miss;
    logic [63:0] u_pc, u_target;
    logic [31:0] br_cnt, miss_cnt;

    int errors = 0;
    int checks = 0;

    br_pred dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_pc(f_pc), .f_stall(f_stall), .flush(flush),
        .p_valid(p_valid), .p_pc(p_pc), .p_taken(p_taken), .p_target(p_target),
        .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken), .u_target(u_target),
        .u_miss(u_miss), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic update(input logic [63:0] pc, input logic tk, input logic [63:0] tgt, input logic ms);
        u_valid = 1'b1; u_pc = pc; u_taken = tk; u_target = tgt; u_miss = ms;
        step();
        u_valid = 1'b0; u_miss = 1'b0;
    endtask

    task automatic lookup(input logic [63:0] pc);
        f_valid = 1'b1; f_pc = pc;
        step();
        f_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        f_valid = 0; f_pc = 0; f_stall = 0; flush = 0;
        u_valid = 0; u_pc = 0; u_taken = 0; u_target = 0; u_miss = 0;
        #2;
        checks++; if (p_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_p_valid: got %0h expected 0", p_valid); end
        checks++; if (p_target !== 64'd0) begin errors++; $display("[TB] FAIL reset_p_target: got %0h expected 0", p_target); end
        checks++; if (br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_counters: got %0h/%0h expected 0/0", br_cnt, miss_cnt); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_lookup_basic();
        lookup(64'h1000);
        checks++; if (p_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %0h expected 1", p_valid); end
        checks++; if (p_pc !== 64'h1000) begin errors++; $display("[TB] FAIL basic_pc: got %0h expected 1000", p_pc); end
        checks++; if (p_taken !== 1'b0) begin errors++; $display("[TB] FAIL basic_taken: got %0h expected 0", p_taken); end
        checks++; if (p_target !== 64'h1004) begin errors++; $display("[TB] FAIL basic_target: got %0h expected 1004", p_target); end
        step();
        checks++; if (p_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid: got %0h expected 0", p_valid); end
    endtask

    task automatic test_train();
        update(64'h1000, 1'b1, 64'h2000, 1'b1);
        lookup(64'h1000);
        checks++; if (p_taken !== 1'b1) begin errors++; $display("[TB] FAIL train_taken: got %0h expected 1", p_taken); end
        checks++; if (p_target !== 64'h2000) begin errors++; $display("[TB] FAIL train_target: got %0h expected 2000", p_target); end
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 3; i++) update(64'h1000, 1'b1, 64'h2000, 1'b0);
        update(64'h1000, 1'b0, 64'h0, 1'b0);
        lookup(64'h1000);
        checks++; if (p_taken !== 1'b1) begin errors++; $display("[TB] FAIL hyst_still_taken: got %0h expected 1", p_taken); end
        update(64'h1000, 1'b0, 64'h0, 1'b0);
        update(64'h1000, 1'b0, 64'h0, 1'b0);
        lookup(64'h1000);
        checks++; if (p_taken !== 1'b0) begin errors++; $display("[TB] FAIL hyst_not_taken: got %0h expected 0", p_taken); end
        checks++; if (p_target !== 64'h1004) begin errors++; $display("[TB] FAIL hyst_target: got %0h expected 1004", p_target); end
    endtask

    task automatic test_alias();
        update(64'h1000, 1'b1, 64'h2000, 1'b0);
        update(64'h1000, 1'b1, 64'h2000, 1'b0);
        lookup(64'h1000);
        checks++; if (p_taken !== 1'b1) begin errors++; $display("[TB] FAIL alias_retrain: got %0h expected 1", p_taken); end
        lookup(64'h1100);
        checks++; if (p_taken !== 1'b0) begin errors++; $display("[TB] FAIL alias_taken: got %0h expected 0", p_taken); end
        checks++; if (p_target !== 64'h1104) begin errors++; $display("[TB] FAIL alias_target: got %0h expected 1104", p_target); end
        update(64'h1100, 1'b1, 64'h5000, 1'b0);
        lookup(64'h1000);
        checks++; if (p_taken !== 1'b0 || p_target !== 64'h1004) begin errors++; $display("[TB] FAIL alias_evicted: got %0h/%0h expected 0/1004", p_taken, p_target); end
        lookup(64'h1100);
        checks++; if (p_taken !== 1'b1 || p_target !== 64'h5000) begin errors++; $display("[TB] FAIL alias_new_owner: got %0h/%0h expected 1/5000", p_taken, p_target); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        f_valid = 1'b1; f_pc = 64'h3000;
        u_valid = 1'b1; u_pc = 64'h3000; u_taken = 1'b1; u_target = 64'h3400;
        step();
        u_valid = 1'b0;
        checks++; if (p_taken !== 1'b0 || p_target !== 64'h3004) begin errors++; $display("[TB] FAIL same_cycle_pre: got %0h/%0h expected 0/3004", p_taken, p_target); end
        step();
        f_valid = 1'b0;
        checks++; if (p_taken !== 1'b1 || p_target !== 64'h3400) begin errors++; $display("[TB] FAIL same_cycle_post: got %0h/%0h expected 1/3400", p_taken, p_target); end
    endtask

    task automatic test_stall();
        f_stall = 1'b1; f_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f_pc = 64'h1000 + 64'(i * 4);
            step();
            checks++;
            if (p_valid !== 1'b1 || p_pc !== 64'h3000 || p_taken !== 1'b1 || p_target !== 64'h3400) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%0h pc=%0h t=%0h tgt=%0h expected 1/3000/1/3400", i, p_valid, p_pc, p_taken, p_target);
            end
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        flush = 1'b0; f_stall = 1'b0; f_valid = 1'b0;
        checks++; if (p_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_over_stall: got %0h expected 0", p_valid); end
    endtask

    task automatic test_counters();
        do_reset();
        update(64'h0040, 1'b1, 64'h0100, 1'b1);
        update(64'h0044, 1'b0, 64'h0000, 1'b0);
        update(64'h0048, 1'b1, 64'h0200, 1'b0);
        update(64'h0040, 1'b0, 64'h0000, 1'b1);
        update(64'h004C, 1'b0, 64'h0000, 1'b0);
        checks++; if (br_cnt !== 32'd5) begin errors++; $display("[TB] FAIL br_cnt: got %0d expected 5", br_cnt); end
        checks++; if (miss_cnt !== 32'd2) begin errors++; $display("[TB] FAIL miss_cnt: got %0d expected 2", miss_cnt); end
    endtask

    task automatic test_mid_reset();
        update(64'h1000, 1'b1, 64'h2000, 1'b0);
        update(64'h1000, 1'b1, 64'h2000, 1'b0);
        lookup(64'h1000);
        checks++; if (p_valid !== 1'b1 || p_taken !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_train: got %0h/%0h expected 1/1", p_valid, p_taken); end
        rst = 1'b1;
        #1;
        checks++; if (p_valid !== 1'b0 || br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin errors++; $display("[TB] FAIL async_reset: got v=%0h br=%0d miss=%0d expected 0/0/0", p_valid, br_cnt, miss_cnt); end
        rst = 1'b0;
        lookup(64'h1000);
        checks++; if (p_taken !== 1'b0 || p_target !== 64'h1004) begin errors++; $display("[TB] FAIL reset_training_lost: got %0h/%0h expected 0/1004", p_taken, p_target); end
    endtask

    initial begin
        test_reset();
        test_lookup_basic();
        test_train();
        test_hysteresis();
        test_alias();
        test_same_cycle();
        test_stall();
        test_flush();
        test_counters();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
